idelay_scan_ctrl: RTL

Calibration controller for one `deserializer` link. On request it sweeps the IDELAY tap setting across its range in fixed steps and checks the recovered 8-bit words against a training pattern at each step. It then finds the longest contiguous error-free window and leaves the delay parked at that window's centre. It sits between the link-capture register interface and the `deserializer` instance: it drives `delay_in`, watches `delay_ready`, and reads `parallel_data`.

---
 rtl/idelay_scan_pkg.sv | 35 +++
 rtl/idelay_scan_ctrl_pattern_checker.sv | 24 ++
 rtl/idelay_scan_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/idelay_scan_pkg.sv
// rtl/idelay_scan_pkg.sv - shared types, widths and the rotation match helper for the IDELAY scan controller
package idelay_scan_pkg;

    localparam int TAP_W  = 9;
    localparam int ERR_W  = 16;
    localparam int BEST_W = $clog2(511 / 8 + 2);
    // Shared phase counter; wide enough for READY_TIMEOUT and 2^DWELL_LOG2 up to 2^15.
    localparam int CNT_W  = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_BLANK,
        S_WAIT_RDY,
        S_SETTLE,
        S_DWELL,
        S_EVAL,
        S_CENTER,
        S_BLANK2,
        S_WAIT_RDY2,
        S_FINISH
    } state_t;

    // Word alignment is unknown during training, so any bit-rotation of the pattern counts as good.
    function automatic logic is_rotation(input logic [7:0] pat, input logic [7:0] word);
        logic [15:0] pp;
        logic        hit;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pp = {pat, pat} << i;
            if (pp[15:8] == word) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/idelay_scan_ctrl_pattern_checker.sv
// rtl/idelay_scan_ctrl_pattern_checker.sv - rotation-tolerant word compare with saturating error counter
module pattern_checker
    import idelay_scan_pkg::*;
(
    input  logic             clk160,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [7:0]       pattern,
    input  logic [7:0]       data,
    output logic [ERR_W-1:0] errors
);

    always_ff @(posedge clk160 or posedge rst) begin
        if (rst) begin
            errors <= '0;
        end else if (clear) begin
            errors <= '0;
        end else if (enable && !is_rotation(pattern, data) && errors != '1) begin
            errors <= errors + ERR_W'(1);
        end
    end

endmodule

// File: rtl/idelay_scan_ctrl.sv
// rtl/idelay_scan_ctrl.sv - sweeps IDELAY taps, finds the widest clean window and parks the delay at its centre
module idelay_scan_ctrl
    import idelay_scan_pkg::*;
#(
    parameter int STEP          = 8,
    parameter int MAX_DELAY     = 511,
    parameter int DWELL_LOG2    = 10,
    parameter int READY_BLANK   = 4,
    parameter int SETTLE        = 16,
    parameter int READY_TIMEOUT = 1023
) (
    input  logic              clk160,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        pattern,
    input  logic [7:0]        parallel_data,
    input  logic              delay_ready,
    output logic [TAP_W-1:0]  delay_set,
    output logic              busy,
    output logic              done,
    output logic              scan_ok,
    output logic              timeout,
    output logic [TAP_W-1:0]  best_start,
    output logic [BEST_W-1:0] best_width
);

    localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(READY_BLANK - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'((1 << DWELL_LOG2) - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(READY_TIMEOUT - 1);

    state_t             state;
    logic [7:0]         pat;
    logic [CNT_W-1:0]   cnt;
    logic [TAP_W-1:0]   cur_start;
    logic [BEST_W-1:0]  cur_len;
    logic [ERR_W-1:0]   errors;
    logic [TAP_W:0]     next_tap;
    logic [BEST_W-1:0]  new_len;
    logic [TAP_W-1:0]   new_start;
    logic               chk_clear;
    logic               chk_enable;

    assign next_tap   = {1'b0, delay_set} + (TAP_W+1)'(STEP);
    assign new_len    = cur_len + BEST_W'(1);
    assign new_start  = (cur_len == '0) ? delay_set : cur_start;
    assign chk_clear  = (state == S_IDLE) || (state == S_EVAL);
    assign chk_enable = (state == S_DWELL);

    pattern_checker u_checker (
        .clk160  (clk160),
        .rst     (rst),
        .clear   (chk_clear),
        .enable  (chk_enable),
        .pattern (pat),
        .data    (parallel_data),
        .errors  (errors)
    );

    always_ff @(posedge clk160 or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pat        <= '0;
            cnt        <= '0;
            cur_start  <= '0;
            cur_len    <= '0;
            delay_set  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            scan_ok    <= 1'b0;
            timeout    <= 1'b0;
            best_start <= '0;
            best_width <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pat        <= pattern;
                        cur_start  <= '0;
                        cur_len    <= '0;
                        best_start <= '0;
                        best_width <= '0;
                        done       <= 1'b0;
                        scan_ok    <= 1'b0;
                        timeout    <= 1'b0;
                        busy       <= 1'b1;
                        delay_set  <= '0;
                        cnt        <= '0;
                        state      <= S_BLANK;
                    end
                end
                // delay_ready may still reflect the previous tap here, so it is ignored.
                S_BLANK, S_BLANK2: begin
                    if (cnt == BLANK_LAST) begin
                        cnt   <= '0;
                        state <= (state == S_BLANK) ? S_WAIT_RDY : S_WAIT_RDY2;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT_RDY, S_WAIT_RDY2: begin
                    if (delay_ready) begin
                        cnt <= '0;
                        if (state == S_WAIT_RDY) begin
                            state <= S_SETTLE;
                        end else begin
                            scan_ok <= (best_width != '0);
                            state   <= S_FINISH;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        timeout <= 1'b1;
                        state   <= S_FINISH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= S_DWELL;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DWELL: begin
                    if (cnt == DWELL_LAST) begin
                        cnt   <= '0;
                        state <= S_EVAL;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_EVAL: begin
                    if (errors == '0) begin
                        cur_start <= new_start;
                        cur_len   <= new_len;
                        // Strict compare keeps the earliest of equally wide windows.
                        if (new_len > best_width) begin
                            best_start <= new_start;
                            best_width <= new_len;
                        end
                    end else begin
                        cur_len <= '0;
                    end
                    if (next_tap > (TAP_W+1)'(MAX_DELAY)) begin
                        state <= S_CENTER;
                    end else begin
                        delay_set <= next_tap[TAP_W-1:0];
                        state     <= S_BLANK;
                    end
                end
                S_CENTER: begin
                    if (best_width != '0) begin
                        delay_set <= TAP_W'({1'b0, best_start}
                                     + ((((TAP_W+1)'(best_width) - (TAP_W+1)'(1)) * (TAP_W+1)'(STEP)) >> 1));
                    end else begin
                        delay_set <= '0;
                    end
                    cnt   <= '0;
                    state <= S_BLANK2;
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
